sd_sector_streamer: RTL and testbench

SD_SECTOR_STREAMER -- requirements
Module: sd_sector_streamer

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sd_sector_streamer_fifo.sv | 75 +++++++
 rtl/sd_sector_streamer.sv | 175 +++++++++++++++++
 tb/tb_sd_sector_streamer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg -- shared definitions for the SD sector streaming path.
//   SD_SECTOR_BYTES : default bytes per SD sector
//   sd_state_e      : sector streamer FSM state encoding
//   fifo_has_room() : free-space test used before issuing a sector read
package sd_pkg;

  localparam int SD_SECTOR_BYTES = 512;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_READ       = 3'd2,
    S_NEXT       = 3'd3,
    S_DONE       = 3'd4
  } sd_state_e;

  // True when a FIFO of 'depth' entries holding 'level' can absorb 'need' more.
  function automatic logic fifo_has_room(input int depth, input int level, input int need);
    return ((depth - level) >= need);
  endfunction

endpackage

// File: rtl/sd_sector_streamer_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO with occupancy output.
//   clk_i, rst_ni   : clock, asynchronous active-low reset (clears pointers/level)
//   push_i, wdata_i : write strobe and data; a push while full is accepted only
//                     when a pop happens in the same cycle, otherwise dropped
//   pop_i           : read strobe, ignored while empty
//   rdata_o         : head entry (valid whenever empty_o is low)
//   full_o, empty_o : status flags
//   level_o         : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (level_q == LVL_ZERO);
  assign full_o    = (level_q == LVL_FULL);
  assign pop_ok_s  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= PTR_ONE - PTR_ONE;
      rd_ptr_q <= PTR_ONE - PTR_ONE;
      level_q  <= LVL_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer -- reads a run of SD sectors and streams the bytes out.
//   sys_clk, rst_n          : clock, asynchronous active-low reset
//   start/start_sector/
//   sector_count            : transfer request (accepted only when idle)
//   busy, done, err         : status; done is a one-cycle pulse, err is sticky
//   sd_init_done            : card ready from the SD controller
//   sd_sec_read(_addr)      : sector read request and address to the controller
//   sd_sec_read_data(_valid): byte stream from the controller (cannot stall)
//   sd_sec_read_end         : sector-complete pulse from the controller
//   m_data/m_valid/m_ready  : first-word-fall-through byte stream to consumer
//   fifo_level              : byte FIFO occupancy
// A sector read is only issued when the FIFO can absorb a whole sector, since
// the controller's byte stream has no back-pressure.
module sd_sector_streamer
  import sd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 1024,
  parameter int SECTOR_BYTES = SD_SECTOR_BYTES
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [31:0]                   start_sector,
  input  logic [15:0]                   sector_count,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          sd_init_done,
  output logic                          sd_sec_read,
  output logic [31:0]                   sd_sec_read_addr,
  input  logic [7:0]                    sd_sec_read_data,
  input  logic                          sd_sec_read_data_valid,
  input  logic                          sd_sec_read_end,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [15:0] SECTOR_BYTES_W = 16'(SECTOR_BYTES);

  sd_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] cnt_now_s;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        init_prev_q;

  logic        push_s, pop_s, room_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_s;

  assign pop_s  = m_ready & ~fifo_empty_s;
  assign room_s = fifo_has_room(FIFO_DEPTH, int'(fifo_level_s), SECTOR_BYTES);
  // Includes a strobe arriving in the same cycle as the end pulse.
  assign cnt_now_s = byte_cnt_q + {15'd0, sd_sec_read_data_valid};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .push_i  (push_s),
    .wdata_i (sd_sec_read_data),
    .pop_i   (pop_s),
    .rdata_o (m_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // FSM next-state, datapath updates and status flags.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    push_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = start_sector;
          remain_d = sector_count;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = (sector_count == 16'd0) ? S_DONE : S_WAIT_SPACE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_SPACE: begin
        if (sd_init_done && room_s) begin
          byte_cnt_d = 16'd0;
          state_d    = S_READ;
        end else begin
          state_d = S_WAIT_SPACE;
        end
      end
      S_READ: begin
        push_s     = sd_sec_read_data_valid;
        byte_cnt_d = cnt_now_s;
        if (!sd_init_done) begin
          // Card lost: abandon this sector and re-read it once the card returns.
          err_d   = 1'b1;
          state_d = S_WAIT_SPACE;
        end else if (sd_sec_read_end) begin
          err_d   = err_q | (cnt_now_s != SECTOR_BYTES_W);
          state_d = S_NEXT;
        end else begin
          state_d = S_READ;
        end
      end
      S_NEXT: begin
        addr_d   = addr_q + 32'd1;
        remain_d = remain_q - 16'd1;
        state_d  = (remain_q == 16'd1) ? S_DONE : S_WAIT_SPACE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Overflow: a byte arriving with nowhere to go is lost.
    err_d = err_d | (push_s & fifo_full_s & ~pop_s);
    // Card-ready dropping at any point of a transfer is an error.
    err_d = err_d | (busy_q & init_prev_q & ~sd_init_done);
    rd_d  = (state_d == S_READ);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'd0;
      remain_q    <= 16'd0;
      byte_cnt_q  <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      init_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      byte_cnt_q  <= byte_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      init_prev_q <= sd_init_done;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign sd_sec_read      = rd_q;
  assign sd_sec_read_addr = addr_q;
  assign m_valid          = ~fifo_empty_s;
  assign fifo_level       = fifo_level_s;

endmodule

// File: tb/tb_sd_sector_streamer.sv
`timescale 1ns/1ps
module tb_sd_sector_streamer;

  localparam int FIFO_DEPTH   = 1024;
  localparam int SECTOR_BYTES = 512;

  logic        sys_clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_sector;
  logic [15:0] sector_count;
  logic        busy, done, err;
  logic        sd_init_done;
  logic        sd_sec_read;
  logic [31:0] sd_sec_read_addr;
  logic [7:0]  sd_sec_read_data;
  logic        sd_sec_read_data_valid;
  logic        sd_sec_read_end;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [10:0] fifo_level;

  sd_sector_streamer #(.FIFO_DEPTH(FIFO_DEPTH), .SECTOR_BYTES(SECTOR_BYTES)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .busy(busy), .done(done), .err(err),
    .sd_init_done(sd_init_done), .sd_sec_read(sd_sec_read),
    .sd_sec_read_addr(sd_sec_read_addr), .sd_sec_read_data(sd_sec_read_data),
    .sd_sec_read_data_valid(sd_sec_read_data_valid), .sd_sec_read_end(sd_sec_read_end),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level)
  );

  typedef struct {
    logic [31:0] sec;
    logic [15:0] cnt;
    int          nbytes;
    int          rmode;    // 0 consumer stalled, 1 always ready, 2 random
    bit          exp_err;
  } vec_t;

  // Reference model: the byte stream the consumer must see, in order.
  logic [7:0] exp_q[$];
  int nvec = 0;
  int nerr = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int popped = 0;
  bit rd_seen = 1'b0;
  logic [7:0] exp_b;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Consumer: drives m_ready and checks every popped byte against the model.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rst_n) begin
        case (ready_mode)
          0:       m_ready = 1'b0;
          1:       m_ready = 1'b1;
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (m_ready && m_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'd1, 32'd0);
          end else begin
            exp_b = exp_q.pop_front();
            chk("stream_byte", {24'd0, m_data}, {24'd0, exp_b});
          end
          popped++;
        end
      end else begin
        m_ready = 1'b0;
      end
    end
  end

  // Event monitor for done pulses and any read request.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (done) done_cnt++;
      if (sd_sec_read) rd_seen = 1'b1;
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [15:0] c);
    start_sector = s;
    sector_count = c;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic push_bytes(input int n);
    logic [7:0] d;
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 3) == 0) @(negedge sys_clk);
      d = 8'($urandom);
      sd_sec_read_data = d;
      sd_sec_read_data_valid = 1'b1;
      exp_q.push_back(d);
      @(negedge sys_clk);
      sd_sec_read_data_valid = 1'b0;
    end
  endtask

  task automatic serve(input int n);
    push_bytes(n);
    sd_sec_read_end = 1'b1;
    @(negedge sys_clk);
    sd_sec_read_end = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (sd_sec_read) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL rd_timeout: sd_sec_read low, expected a read request");
    end
  endtask

  task automatic wait_done(input int d0);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: done never pulsed, expected one pulse");
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (exp_q.size() == 0 && !m_valid) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d bytes left, expected 0", exp_q.size());
    end
  endtask

  task automatic run_xfer(input vec_t v);
    bit ok;
    int d0, p0;
    ready_mode = v.rmode;
    d0 = done_cnt;
    p0 = popped;
    do_start(v.sec, v.cnt);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared", {31'd0, err}, 32'd0);
    for (int s = 0; s < int'(v.cnt); s++) begin
      wait_rd(ok);
      if (!ok) return;
      chk("sector_addr", sd_sec_read_addr, v.sec + 32'(s));
      serve(v.nbytes);
      chk("rd_dropped_after_end", {31'd0, sd_sec_read}, 32'd0);
    end
    wait_done(d0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("err_flag", {31'd0, err}, {31'd0, v.exp_err});
    wait_drain();
    chk("level_drained", {21'd0, fifo_level}, 32'd0);
    chk("bytes_out", 32'(popped - p0), 32'(int'(v.cnt) * v.nbytes));
  endtask

  initial begin
    vec_t tbl[$];
    int d0, p0;
    bit ok;

    rst_n = 1'b0;
    start = 1'b0;
    start_sector = 32'd0;
    sector_count = 16'd0;
    sd_init_done = 1'b1;
    sd_sec_read_data = 8'd0;
    sd_sec_read_data_valid = 1'b0;
    sd_sec_read_end = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_sd_sec_read", {31'd0, sd_sec_read}, 32'd0);
    chk("rst_addr", sd_sec_read_addr, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_level", {21'd0, fifo_level}, 32'd0);

    // Transfer table: directed cases first, then randomized ones.
    tbl.push_back('{sec: 32'h0000_0100, cnt: 16'd2, nbytes: 512, rmode: 1, exp_err: 1'b0});
    tbl.push_back('{sec: 32'hFFFF_FFFF, cnt: 16'd2, nbytes: 512, rmode: 1, exp_err: 1'b0});
    tbl.push_back('{sec: 32'h0000_0020, cnt: 16'd1, nbytes: 500, rmode: 1, exp_err: 1'b1});
    tbl.push_back('{sec: 32'h0000_0040, cnt: 16'd3, nbytes: 512, rmode: 2, exp_err: 1'b0});
    tbl.push_back('{sec: 32'h0000_0007, cnt: 16'd1, nbytes: 520, rmode: 2, exp_err: 1'b1});
    for (int r = 0; r < 3; r++) begin
      tbl.push_back('{sec: $urandom, cnt: 16'($urandom_range(1, 3)), nbytes: 512,
                      rmode: $urandom_range(1, 2), exp_err: 1'b0});
    end
    foreach (tbl[i]) run_xfer(tbl[i]);

    // Zero sectors: done two cycles after start, no read issued.
    ready_mode = 1;
    rd_seen = 1'b0;
    do_start(32'h55, 16'd0);
    chk("zero_busy", {31'd0, busy}, 32'd1);
    chk("zero_done_early", {31'd0, done}, 32'd0);
    @(negedge sys_clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    chk("zero_done_one_cycle", {31'd0, done}, 32'd0);
    chk("zero_no_read", {31'd0, rd_seen}, 32'd0);

    // Flow control with a stalled consumer; a start while busy is ignored.
    ready_mode = 0;
    d0 = done_cnt;
    do_start(32'h300, 16'd3);
    wait_rd(ok);
    chk("fc_addr0", sd_sec_read_addr, 32'h300);
    serve(SECTOR_BYTES);
    wait_rd(ok);
    chk("fc_addr1", sd_sec_read_addr, 32'h301);
    chk("fc_level_512", {21'd0, fifo_level}, 32'd512);
    serve(SECTOR_BYTES);
    repeat (3) @(negedge sys_clk);
    chk("fc_level_1024", {21'd0, fifo_level}, 32'd1024);
    do_start(32'hDEAD, 16'd9);
    rd_seen = 1'b0;
    repeat (60) @(negedge sys_clk);
    chk("fc_no_third_read", {31'd0, rd_seen}, 32'd0);
    ready_mode = 1;
    wait_rd(ok);
    chk("fc_addr2", sd_sec_read_addr, 32'h302);
    chk("fc_space_at_third", {31'd0, fifo_level <= 11'd512}, 32'd1);
    serve(SECTOR_BYTES);
    wait_done(d0);
    chk("fc_done_pulses", 32'(done_cnt - d0), 32'd1);
    wait_drain();
    chk("fc_level_drained", {21'd0, fifo_level}, 32'd0);

    // Card drops mid-sector: error, read dropped, stray strobes ignored, same sector re-read.
    ready_mode = 1;
    d0 = done_cnt;
    p0 = popped;
    do_start(32'h500, 16'd1);
    wait_rd(ok);
    push_bytes(100);
    sd_init_done = 1'b0;
    @(negedge sys_clk);
    chk("drop_rd_low", {31'd0, sd_sec_read}, 32'd0);
    chk("drop_err", {31'd0, err}, 32'd1);
    sd_sec_read_data = 8'hEE;
    sd_sec_read_data_valid = 1'b1;
    repeat (3) @(negedge sys_clk);
    sd_sec_read_data_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("drop_still_waiting", {31'd0, sd_sec_read}, 32'd0);
    sd_init_done = 1'b1;
    wait_rd(ok);
    chk("drop_reread_addr", sd_sec_read_addr, 32'h500);
    serve(SECTOR_BYTES);
    wait_done(d0);
    chk("drop_err_sticky", {31'd0, err}, 32'd1);
    wait_drain();
    chk("drop_bytes_out", 32'(popped - p0), 32'd612);

    // Reset in the middle of a sector clears everything immediately.
    ready_mode = 0;
    do_start(32'h700, 16'd2);
    wait_rd(ok);
    push_bytes(200);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", {31'd0, sd_sec_read}, 32'd0);
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_level", {21'd0, fifo_level}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    run_xfer('{sec: 32'h900, cnt: 16'd1, nbytes: 512, rmode: 1, exp_err: 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
